// File: rtl/fetch_unit.sv
// Instruction fetch FSM: IDLE -> WAIT (memory read) -> LOAD (IR + PC load pulse) -> IDLE.
// Define FETCH_TIMEOUT_EN to add a WAIT timeout that parks the FSM in FAULT until Reset.
module fetch_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Run,
  input  logic [15:0] PC_in,
  input  logic [15:0] Mem_rdata,
  input  logic        Mem_ready,
  output logic [15:0] Mem_addr,
  output logic        Mem_rd,
  output logic [15:0] IR_out,
  output logic        IR_valid,
  output logic        LD_PC,
  output logic [1:0]  PCMUX,
  output logic        Busy,
  output logic        Fault,
  output logic [7:0]  Fetch_count
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic [1:0] {StIdle, StWait, StLoad, StFault} state_e;

  state_e      r_state;
  logic [15:0] r_mar;
  logic [15:0] r_ir;
  logic        r_ir_valid;
  logic        r_ld_pc;
  logic        r_mem_rd;
  logic        r_busy;
  logic [7:0]  r_fetch_count;

`ifdef FETCH_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

  logic [CntW-1:0] r_wait_cnt;
  logic            r_fault;
`endif

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state       <= StIdle;
      r_mar         <= 16'h0000;
      r_ir          <= 16'h0000;
      r_ir_valid    <= 1'b0;
      r_ld_pc       <= 1'b0;
      r_mem_rd      <= 1'b0;
      r_busy        <= 1'b0;
      r_fetch_count <= 8'h00;
`ifdef FETCH_TIMEOUT_EN
      r_wait_cnt    <= '0;
      r_fault       <= 1'b0;
`endif
    end else begin
      r_ld_pc <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (Run) begin
            r_mar      <= PC_in;
            r_ir_valid <= 1'b0;
            r_mem_rd   <= 1'b1;
            r_busy     <= 1'b1;
            r_state    <= StWait;
`ifdef FETCH_TIMEOUT_EN
            r_wait_cnt <= '0;
`endif
          end
        end
        StWait: begin
          // Ready on the final allowed WAIT cycle still completes the fetch.
          if (Mem_ready) begin
            r_ir          <= Mem_rdata;
            r_ir_valid    <= 1'b1;
            r_ld_pc       <= 1'b1;
            r_mem_rd      <= 1'b0;
            r_fetch_count <= r_fetch_count + 8'd1;
            r_state       <= StLoad;
          end
`ifdef FETCH_TIMEOUT_EN
          else if (r_wait_cnt == CntLast) begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
            r_mem_rd   <= 1'b0;
            r_fault    <= 1'b1;
            r_state    <= StFault;
          end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
          end
`endif
        end
        StLoad: begin
          r_busy  <= 1'b0;
          r_state <= StIdle;
        end
        StFault: begin
          r_state <= StFault;
        end
      endcase
    end
  end

  assign Mem_addr    = r_mar;
  assign Mem_rd      = r_mem_rd;
  assign IR_out      = r_ir;
  assign IR_valid    = r_ir_valid;
  assign LD_PC       = r_ld_pc;
  assign PCMUX       = 2'b00;
  assign Busy        = r_busy;
  assign Fetch_count = r_fetch_count;
`ifdef FETCH_TIMEOUT_EN
  assign Fault       = r_fault;
`else
  assign Fault       = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit; covers the FETCH_TIMEOUT_EN build when defined.
module tb_fetch_unit;

  logic        Clk;
  logic        Reset;
  logic        Run;
  logic [15:0] PC_in;
  logic [15:0] Mem_rdata;
  logic        Mem_ready;
  logic [15:0] Mem_addr;
  logic        Mem_rd;
  logic [15:0] IR_out;
  logic        IR_valid;
  logic        LD_PC;
  logic [1:0]  PCMUX;
  logic        Busy;
  logic        Fault;
  logic [7:0]  Fetch_count;

  int n_cmp = 0;
  int n_bad = 0;

  fetch_unit #(.TIMEOUT_CYCLES(16)) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .Run        (Run),
    .PC_in      (PC_in),
    .Mem_rdata  (Mem_rdata),
    .Mem_ready  (Mem_ready),
    .Mem_addr   (Mem_addr),
    .Mem_rd     (Mem_rd),
    .IR_out     (IR_out),
    .IR_valid   (IR_valid),
    .LD_PC      (LD_PC),
    .PCMUX      (PCMUX),
    .Busy       (Busy),
    .Fault      (Fault),
    .Fetch_count(Fetch_count)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Outputs are sampled 1 time unit after the rising edge, inputs change there too.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    Reset = 1'b1; Run = 1'b1; Mem_ready = 1'b1; PC_in = 16'hFFFF; Mem_rdata = 16'hFFFF;
    tick(); tick();
    n_cmp++; if (Mem_addr !== 16'h0000) begin n_bad++; $display("FAIL reset_addr: got %h want 0000", Mem_addr); end
    n_cmp++; if (Mem_rd !== 1'b0) begin n_bad++; $display("FAIL reset_mem_rd: got %b want 0", Mem_rd); end
    n_cmp++; if (IR_out !== 16'h0000) begin n_bad++; $display("FAIL reset_ir: got %h want 0000", IR_out); end
    n_cmp++; if (IR_valid !== 1'b0) begin n_bad++; $display("FAIL reset_ir_valid: got %b want 0", IR_valid); end
    n_cmp++; if (LD_PC !== 1'b0) begin n_bad++; $display("FAIL reset_ld_pc: got %b want 0", LD_PC); end
    n_cmp++; if (PCMUX !== 2'b00) begin n_bad++; $display("FAIL reset_pcmux: got %b want 00", PCMUX); end
    n_cmp++; if (Busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", Busy); end
    n_cmp++; if (Fault !== 1'b0) begin n_bad++; $display("FAIL reset_fault: got %b want 0", Fault); end
    n_cmp++; if (Fetch_count !== 8'h00) begin n_bad++; $display("FAIL reset_count: got %h want 00", Fetch_count); end
    Reset = 1'b0; Run = 1'b0; Mem_ready = 1'b0;
    tick();
    n_cmp++; if (Busy !== 1'b0) begin n_bad++; $display("FAIL post_reset_busy: got %b want 0", Busy); end
    n_cmp++; if (Mem_rd !== 1'b0) begin n_bad++; $display("FAIL post_reset_mem_rd: got %b want 0", Mem_rd); end
  endtask

  task automatic test_basic_fetch();
    PC_in = 16'h3000; Run = 1'b1;
    tick();
    n_cmp++; if (Mem_addr !== 16'h3000) begin n_bad++; $display("FAIL basic_addr: got %h want 3000", Mem_addr); end
    n_cmp++; if (Mem_rd !== 1'b1) begin n_bad++; $display("FAIL basic_mem_rd: got %b want 1", Mem_rd); end
    n_cmp++; if (Busy !== 1'b1) begin n_bad++; $display("FAIL basic_busy_wait: got %b want 1", Busy); end
    n_cmp++; if (LD_PC !== 1'b0) begin n_bad++; $display("FAIL basic_ld_pc_wait: got %b want 0", LD_PC); end
    Run = 1'b0; Mem_ready = 1'b1; Mem_rdata = 16'h1234;
    tick();
    n_cmp++; if (Mem_rd !== 1'b0) begin n_bad++; $display("FAIL basic_mem_rd_load: got %b want 0", Mem_rd); end
    n_cmp++; if (LD_PC !== 1'b1) begin n_bad++; $display("FAIL basic_ld_pc: got %b want 1", LD_PC); end
    n_cmp++; if (IR_out !== 16'h1234) begin n_bad++; $display("FAIL basic_ir: got %h want 1234", IR_out); end
    n_cmp++; if (IR_valid !== 1'b1) begin n_bad++; $display("FAIL basic_ir_valid: got %b want 1", IR_valid); end
    n_cmp++; if (Fetch_count !== 8'h01) begin n_bad++; $display("FAIL basic_count: got %h want 01", Fetch_count); end
    n_cmp++; if (PCMUX !== 2'b00) begin n_bad++; $display("FAIL basic_pcmux: got %b want 00", PCMUX); end
    Mem_ready = 1'b0; Mem_rdata = 16'hDEAD;
    tick();
    n_cmp++; if (LD_PC !== 1'b0) begin n_bad++; $display("FAIL basic_ld_pc_idle: got %b want 0", LD_PC); end
    n_cmp++; if (Busy !== 1'b0) begin n_bad++; $display("FAIL basic_busy_idle: got %b want 0", Busy); end
    n_cmp++; if (IR_out !== 16'h1234) begin n_bad++; $display("FAIL basic_ir_hold: got %h want 1234", IR_out); end
    n_cmp++; if (IR_valid !== 1'b1) begin n_bad++; $display("FAIL basic_ir_valid_hold: got %b want 1", IR_valid); end
  endtask

  task automatic test_ready_ignored_idle();
    Mem_ready = 1'b1; Mem_rdata = 16'h5555;
    tick(); tick();
    n_cmp++; if (IR_out !== 16'h1234) begin n_bad++; $display("FAIL idle_ready_ir: got %h want 1234", IR_out); end
    n_cmp++; if (Fetch_count !== 8'h01) begin n_bad++; $display("FAIL idle_ready_count: got %h want 01", Fetch_count); end
    n_cmp++; if (Busy !== 1'b0) begin n_bad++; $display("FAIL idle_ready_busy: got %b want 0", Busy); end
    Mem_ready = 1'b0;
  endtask

  task automatic test_delayed_ready();
    PC_in = 16'h4567; Run = 1'b1; Mem_rdata = 16'hBEEF;
    tick();
    Run = 1'b0; PC_in = 16'h9999;
    for (int i = 0; i < 6; i++) begin
      n_cmp++; if (Mem_rd !== 1'b1) begin n_bad++; $display("FAIL delay_mem_rd[%0d]: got %b want 1", i, Mem_rd); end
      n_cmp++; if (Mem_addr !== 16'h4567) begin n_bad++; $display("FAIL delay_addr[%0d]: got %h want 4567", i, Mem_addr); end
      n_cmp++; if (LD_PC !== 1'b0) begin n_bad++; $display("FAIL delay_ld_pc[%0d]: got %b want 0", i, LD_PC); end
      n_cmp++; if (IR_valid !== 1'b0) begin n_bad++; $display("FAIL delay_ir_valid[%0d]: got %b want 0", i, IR_valid); end
      if (i == 5) begin Mem_ready = 1'b1; Mem_rdata = 16'hABCD; end
      tick();
    end
    Mem_ready = 1'b0;
    n_cmp++; if (LD_PC !== 1'b1) begin n_bad++; $display("FAIL delay_ld_pc: got %b want 1", LD_PC); end
    n_cmp++; if (IR_out !== 16'hABCD) begin n_bad++; $display("FAIL delay_ir: got %h want abcd", IR_out); end
    n_cmp++; if (Fetch_count !== 8'h02) begin n_bad++; $display("FAIL delay_count: got %h want 02", Fetch_count); end
    tick();
    n_cmp++; if (LD_PC !== 1'b0) begin n_bad++; $display("FAIL delay_ld_pc_after: got %b want 0", LD_PC); end
    n_cmp++; if (Mem_rd !== 1'b0) begin n_bad++; $display("FAIL delay_mem_rd_after: got %b want 0", Mem_rd); end
  endtask

  task automatic test_back_to_back();
    PC_in = 16'h0100; Run = 1'b1; Mem_ready = 1'b1; Mem_rdata = 16'h7777;
    for (int i = 0; i < 9; i++) begin
      tick();
      n_cmp++; if (LD_PC !== (i % 3 == 1)) begin n_bad++; $display("FAIL b2b_ld_pc[%0d]: got %b want %b", i, LD_PC, (i % 3 == 1)); end
      n_cmp++; if (Busy !== (i % 3 != 2)) begin n_bad++; $display("FAIL b2b_busy[%0d]: got %b want %b", i, Busy, (i % 3 != 2)); end
      n_cmp++; if (Mem_rd !== (i % 3 == 0)) begin n_bad++; $display("FAIL b2b_mem_rd[%0d]: got %b want %b", i, Mem_rd, (i % 3 == 0)); end
    end
    n_cmp++; if (Fetch_count !== 8'h05) begin n_bad++; $display("FAIL b2b_count: got %h want 05", Fetch_count); end
    Run = 1'b0; Mem_ready = 1'b0;
    tick();
    n_cmp++; if (Busy !== 1'b0) begin n_bad++; $display("FAIL b2b_stop_busy: got %b want 0", Busy); end
  endtask

  task automatic test_reset_mid_wait();
    PC_in = 16'h2222; Run = 1'b1;
    tick();
    n_cmp++; if (Mem_rd !== 1'b1) begin n_bad++; $display("FAIL abort_in_wait: got %b want 1", Mem_rd); end
    Reset = 1'b1; Mem_ready = 1'b1; Mem_rdata = 16'h3333;
    tick();
    n_cmp++; if (Mem_rd !== 1'b0) begin n_bad++; $display("FAIL abort_mem_rd: got %b want 0", Mem_rd); end
    n_cmp++; if (LD_PC !== 1'b0) begin n_bad++; $display("FAIL abort_ld_pc: got %b want 0", LD_PC); end
    n_cmp++; if (IR_out !== 16'h0000) begin n_bad++; $display("FAIL abort_ir: got %h want 0000", IR_out); end
    n_cmp++; if (Fetch_count !== 8'h00) begin n_bad++; $display("FAIL abort_count: got %h want 00", Fetch_count); end
    n_cmp++; if (Busy !== 1'b0) begin n_bad++; $display("FAIL abort_busy: got %b want 0", Busy); end
    Reset = 1'b0; Run = 1'b0; Mem_ready = 1'b0;
    tick();
    n_cmp++; if (LD_PC !== 1'b0) begin n_bad++; $display("FAIL abort_ld_pc_after: got %b want 0", LD_PC); end
    n_cmp++; if (Busy !== 1'b0) begin n_bad++; $display("FAIL abort_busy_after: got %b want 0", Busy); end
  endtask

  task automatic test_count_wrap();
    Run = 1'b1; Mem_ready = 1'b1; PC_in = 16'h0040; Mem_rdata = 16'h0F0F;
    for (int i = 1; i <= 767; i++) begin
      tick();
      if (i == 764) begin
        n_cmp++; if (Fetch_count !== 8'hFF) begin n_bad++; $display("FAIL wrap_count_ff: got %h want ff", Fetch_count); end
      end
    end
    n_cmp++; if (Fetch_count !== 8'h00) begin n_bad++; $display("FAIL wrap_count_00: got %h want 00", Fetch_count); end
    n_cmp++; if (LD_PC !== 1'b1) begin n_bad++; $display("FAIL wrap_ld_pc: got %b want 1", LD_PC); end
    Run = 1'b0; Mem_ready = 1'b0;
    tick();
  endtask

`ifdef FETCH_TIMEOUT_EN
  task automatic test_timeout();
    Reset = 1'b1; tick(); Reset = 1'b0;
    PC_in = 16'h5000; Run = 1'b1; Mem_ready = 1'b0;
    tick();
    Run = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      n_cmp++; if (Mem_rd !== 1'b1 || Fault !== 1'b0) begin n_bad++; $display("FAIL to_wait[%0d]: got rd=%b fault=%b want rd=1 fault=0", k, Mem_rd, Fault); end
      tick();
    end
    n_cmp++; if (Fault !== 1'b1) begin n_bad++; $display("FAIL to_fault: got %b want 1", Fault); end
    n_cmp++; if (Mem_rd !== 1'b0) begin n_bad++; $display("FAIL to_fault_mem_rd: got %b want 0", Mem_rd); end
    n_cmp++; if (Busy !== 1'b1) begin n_bad++; $display("FAIL to_fault_busy: got %b want 1", Busy); end
    Mem_ready = 1'b1; Run = 1'b1;
    tick(); tick(); tick();
    n_cmp++; if (Fault !== 1'b1 || LD_PC !== 1'b0) begin n_bad++; $display("FAIL to_fault_hold: got fault=%b ld=%b want 1/0", Fault, LD_PC); end
    Reset = 1'b1; Run = 1'b0; Mem_ready = 1'b0;
    tick();
    Reset = 1'b0;
    n_cmp++; if (Fault !== 1'b0) begin n_bad++; $display("FAIL to_reset_fault: got %b want 0", Fault); end
    Run = 1'b1;
    tick();
    Run = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      if (k == 16) begin Mem_ready = 1'b1; Mem_rdata = 16'h6161; end
      tick();
    end
    Mem_ready = 1'b0;
    n_cmp++; if (LD_PC !== 1'b1) begin n_bad++; $display("FAIL to_last_ready_ld: got %b want 1", LD_PC); end
    n_cmp++; if (Fault !== 1'b0) begin n_bad++; $display("FAIL to_last_ready_fault: got %b want 0", Fault); end
    tick();
  endtask
`else
  task automatic test_no_timeout();
    PC_in = 16'h5000; Run = 1'b1; Mem_ready = 1'b0;
    tick();
    Run = 1'b0;
    for (int k = 0; k < 40; k++) tick();
    n_cmp++; if (Mem_rd !== 1'b1) begin n_bad++; $display("FAIL nto_mem_rd: got %b want 1", Mem_rd); end
    n_cmp++; if (Fault !== 1'b0) begin n_bad++; $display("FAIL nto_fault: got %b want 0", Fault); end
    Mem_ready = 1'b1; Mem_rdata = 16'h6161;
    tick();
    Mem_ready = 1'b0;
    n_cmp++; if (LD_PC !== 1'b1 || IR_out !== 16'h6161) begin n_bad++; $display("FAIL nto_load: got ld=%b ir=%h want 1/6161", LD_PC, IR_out); end
    tick();
  endtask
`endif

  initial begin
    Reset = 1'b1; Run = 1'b0; PC_in = '0; Mem_rdata = '0; Mem_ready = 1'b0;
    test_reset();
    test_basic_fetch();
    test_ready_ignored_idle();
    test_delayed_ready();
    test_back_to_back();
    test_reset_mid_wait();
    test_count_wrap();
`ifdef FETCH_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16, the maximum number of WAIT cycles before fault (used only with FETCH_TIMEOUT_EN).
REQ-002 SHALL have port Clk  input  1  sole clock; all state updates on posedge Clk.
REQ-003 SHALL have port Reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port Run  input  1  request to fetch the instruction at PC_in.
REQ-005 SHALL have port PC_in  input  16  current PC value from the PC register.
REQ-006 SHALL have port Mem_rdata  input  16  memory read data, valid when Mem_ready=1.
REQ-007 SHALL have port Mem_ready  input  1  memory read-complete handshake.
REQ-008 SHALL have port Mem_addr  output  16  memory address (registered MAR).
REQ-009 SHALL have port Mem_rd  output  1  memory read strobe.
REQ-010 SHALL have port IR_out  output  16  fetched instruction register.
REQ-011 SHALL have port IR_valid  output  1  IR_out holds a completed fetch.
REQ-012 SHALL have port LD_PC  output  1  one-cycle PC load pulse to the PC register.
REQ-013 SHALL have port PCMUX  output  2  PC source select to the PC register, constant 2'b00 (PC+1).
REQ-014 SHALL have port Busy  output  1  high in any state other than IDLE.
REQ-015 SHALL have port Fault  output  1  fetch timeout flag.
REQ-016 SHALL have port Fetch_count  output  8  number of completed fetches, modulo 256.

Function
REQ-017 SHALL implement the FSM states IDLE, WAIT, LOAD and FAULT.
REQ-018 In IDLE with Run=1, the block SHALL latch MAR<=PC_in, clear IR_valid and go to WAIT next cycle; with Run=0 it SHALL stay in IDLE.
REQ-019 SHALL drive Mem_addr=MAR at all times and Mem_rd=1 exactly while the state is WAIT.
REQ-020 In WAIT with Mem_ready=1, the block SHALL latch IR<=Mem_rdata and go to LOAD; with Mem_ready=0 it SHALL stay in WAIT and hold MAR.
REQ-021 Mem_ready sampled in the first WAIT cycle SHALL be accepted, giving a minimum of 2 cycles from Run sample to the LOAD state.
REQ-022 In LOAD, LD_PC SHALL be 1 for exactly that one cycle, IR_valid SHALL be 1, and Fetch_count SHALL increment, wrapping 8'hFF->8'h00.
REQ-023 LOAD SHALL always go to IDLE next cycle, and Run asserted during LOAD SHALL be ignored (sampled again in IDLE).
REQ-024 IR_valid SHALL remain 1 from LOAD until the next Run acceptance in IDLE; IR_out SHALL hold its value until the next LOAD.
REQ-025 Mem_ready in IDLE, LOAD or FAULT SHALL be ignored.
REQ-026 LD_PC SHALL be 0 in every state except LOAD; PCMUX SHALL be 2'b00 in all states, including reset.
REQ-027 FAULT SHALL hold Mem_rd=0, LD_PC=0, Busy=1 and Fault=1, and SHALL exit only via Reset.

Reset
REQ-028 Reset=1 at a posedge SHALL force next state IDLE with MAR=0, IR_out=0, IR_valid=0, Fetch_count=0, Fault=0 and the timeout counter=0, taking priority over all other inputs.
REQ-029 During reset and the cycle after, Mem_rd=0, LD_PC=0 and Busy=0; Reset asserted mid-WAIT SHALL abort the fetch with no LD_PC pulse.

Configuration
REQ-030 With FETCH_TIMEOUT_EN defined, a counter SHALL clear on WAIT entry and increment each WAIT cycle with Mem_ready=0.
REQ-031 With FETCH_TIMEOUT_EN defined, after TIMEOUT_CYCLES consecutive WAIT cycles without Mem_ready the next state SHALL be FAULT, and Mem_ready=1 on that last WAIT cycle SHALL win (go to LOAD).
REQ-032 Without FETCH_TIMEOUT_EN, WAIT SHALL persist indefinitely, Fault SHALL be tied 0, FAULT SHALL be unreachable, and no counter logic SHALL be present.

Verification
REQ-033 Reset; PC_in=16'h3000, Run pulse, Mem_ready=1 in first WAIT with Mem_rdata=16'h1234 -> Mem_addr=16'h3000 with Mem_rd=1 for 1 cycle, then IR_out=16'h1234, IR_valid=1, LD_PC=1 for 1 cycle, PCMUX=2'b00, Fetch_count=1.
REQ-034 Mem_ready delayed 5 cycles -> Mem_rd held 6 cycles, Mem_addr stable, single LD_PC pulse.
REQ-035 Run held high continuously for 3 fetches -> pattern WAIT,LOAD,IDLE repeats with LD_PC every 3rd cycle and Fetch_count=3.
REQ-036 Reset asserted during WAIT -> next cycle IDLE, Mem_rd=0, no LD_PC, IR_out=0, Fetch_count=0.
REQ-037 256 back-to-back fetches -> Fetch_count wraps to 8'h00.
REQ-038 With FETCH_TIMEOUT_EN, TIMEOUT_CYCLES=16 and Mem_ready never asserted -> FAULT entered after 16 WAIT cycles, Fault=1 until Reset; Mem_ready on the 16th WAIT cycle -> LOAD, Fault=0.
